// File: rtl/load_store_unit.sv
// Registered RV32I load/store engine for a handshaked, variable-latency data bus.
// Define LSU_MISALIGNED_EN to split misaligned accesses into two word beats.
module load_store_unit #(
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic [1:0]        rsp_err,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [3:0]        mem_wmask,
  output logic [31:0]       mem_wdata,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_err
);

  typedef enum logic [2:0] {
    IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP
  } state_t;

  localparam logic [1:0] E_OK  = 2'b00;
  localparam logic [1:0] E_MIS = 2'b01;
  localparam logic [1:0] E_BUS = 2'b10;
  localparam logic [1:0] E_ILL = 2'b11;

  localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] LAST =
    CW'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);

  state_t        state_q;
  logic          st_q;
  logic [2:0]    f3_q;
  logic [1:0]    off_q;
  logic [CW-1:0] cnt_q;

`ifdef LSU_MISALIGNED_EN
  logic [31:0]   wdata_q;
  logic [31:0]   beat0_q;
`endif

  function automatic logic illegal_f3(
    input logic       st,
    input logic [2:0] f
  );
    if (st) return f[2] || (f[1:0] == 2'b11);
    return (f == 3'b011) || (f == 3'b110) ||
           (f == 3'b111);
  endfunction

  function automatic logic misal(
    input logic [1:0] sz,
    input logic [1:0] off
  );
    return ((sz == 2'b01) && (off == 2'b11)) ||
           ((sz == 2'b10) && (off != 2'b00));
  endfunction

  // hi selects the upper half of the 8-lane window for beat 1
  function automatic logic [3:0] lane_mask(
    input logic [1:0] sz,
    input logic [1:0] off,
    input logic       hi
  );
    logic [3:0] m;
    logic [7:0] w;
    unique case (1'b1)
      sz == 2'b00: m = 4'b0001;
      sz == 2'b01: m = 4'b0011;
      default:     m = 4'b1111;
    endcase
    w = {4'b0000, m} << off;
    return hi ? w[7:4] : w[3:0];
  endfunction

  function automatic logic [31:0] lane_data(
    input logic [31:0] d,
    input logic [1:0]  off,
    input logic        hi
  );
    logic [63:0] w;
    w = {32'h0, d} << {off, 3'b000};
    return hi ? w[63:32] : w[31:0];
  endfunction

  function automatic logic [31:0] load_fmt(
    input logic [63:0] w,
    input logic [2:0]  f,
    input logic [1:0]  off
  );
    logic [31:0] s;
    logic [31:0] r;
    s = 32'(w >> {off, 3'b000});
    unique case (1'b1)
      f[1:0] == 2'b00:
        r = f[2] ? {24'h0, s[7:0]}
                 : {{24{s[7]}}, s[7:0]};
      f[1:0] == 2'b01:
        r = f[2] ? {16'h0, s[15:0]}
                 : {{16{s[15]}}, s[15:0]};
      default: r = s;
    endcase
    return r;
  endfunction

  assign req_ready = (state_q == IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      st_q      <= 1'b0;
      f3_q      <= 3'b000;
      off_q     <= 2'b00;
      cnt_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= 32'h0;
      rsp_err   <= E_OK;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wmask <= 4'b0000;
      mem_wdata <= 32'h0;
`ifdef LSU_MISALIGNED_EN
      wdata_q   <= 32'h0;
      beat0_q   <= 32'h0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            st_q  <= req_store;
            f3_q  <= req_funct3;
            off_q <= req_addr[1:0];
`ifdef LSU_MISALIGNED_EN
            wdata_q <= req_wdata;
`endif
            if (illegal_f3(req_store, req_funct3)) begin
              state_q   <= RESP;
              rsp_valid <= 1'b1;
              rsp_data  <= 32'h0;
              rsp_err   <= E_ILL;
`ifndef LSU_MISALIGNED_EN
            end else if (misal(req_funct3[1:0],
                               req_addr[1:0])) begin
              state_q   <= RESP;
              rsp_valid <= 1'b1;
              rsp_data  <= 32'h0;
              rsp_err   <= E_MIS;
`endif
            end else begin
              state_q  <= REQ0;
              cnt_q    <= '0;
              mem_req  <= 1'b1;
              mem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
              mem_we   <= req_store;
              mem_wmask <= req_store ?
                lane_mask(req_funct3[1:0],
                          req_addr[1:0], 1'b0) : 4'b0000;
              mem_wdata <= req_store ?
                lane_data(req_wdata,
                          req_addr[1:0], 1'b0) : 32'h0;
            end
          end
        end
        REQ0, REQ1: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            state_q <= (state_q == REQ0) ? WAIT0 : WAIT1;
          end else if ((MAX_WAIT != 0) &&
                       (cnt_q == LAST)) begin
            mem_req   <= 1'b0;
            state_q   <= RESP;
            rsp_valid <= 1'b1;
            rsp_data  <= 32'h0;
            rsp_err   <= E_BUS;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        WAIT0: begin
          if (mem_rvalid) begin
            if (mem_err) begin
              state_q   <= RESP;
              rsp_valid <= 1'b1;
              rsp_data  <= 32'h0;
              rsp_err   <= E_BUS;
`ifdef LSU_MISALIGNED_EN
            end else if (misal(f3_q[1:0], off_q)) begin
              beat0_q  <= mem_rdata;
              state_q  <= REQ1;
              cnt_q    <= '0;
              mem_req  <= 1'b1;
              mem_addr <= mem_addr + ADDR_W'(4);
              mem_wmask <= st_q ?
                lane_mask(f3_q[1:0], off_q, 1'b1) : 4'b0000;
              mem_wdata <= st_q ?
                lane_data(wdata_q, off_q, 1'b1) : 32'h0;
`endif
            end else begin
              state_q   <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= E_OK;
              rsp_data  <= st_q ? 32'h0 :
                load_fmt({32'h0, mem_rdata}, f3_q, off_q);
            end
          end
        end
`ifdef LSU_MISALIGNED_EN
        WAIT1: begin
          if (mem_rvalid) begin
            state_q   <= RESP;
            rsp_valid <= 1'b1;
            if (mem_err) begin
              rsp_data <= 32'h0;
              rsp_err  <= E_BUS;
            end else begin
              rsp_err  <= E_OK;
              rsp_data <= st_q ? 32'h0 :
                load_fmt({mem_rdata, beat0_q}, f3_q, off_q);
            end
          end
        end
`endif
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a zero-wait bus model.
// Covers the LSU_MISALIGNED_EN build and the default build.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_err;
  logic        mem_req;
  logic        mem_gnt;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_err = 1'b0;

  logic [31:0] mem [0:255];
  logic        gnt_en = 1'b1;
  logic        err_arm = 1'b0;
  int          beats = 0;
  int          req_hi = 0;
  logic [31:0] g_addr = 32'h0;
  logic        g_we = 1'b0;
  logic [3:0]  g_wmask = 4'h0;
  logic [31:0] g_wdata = 32'h0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] r_data;
  logic [1:0]  r_err;
  int          r_lat;
  int          b0;
  int          rh0;

  load_store_unit #(.ADDR_W(32), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_store(req_store), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mem_req(mem_req), .mem_gnt(mem_gnt),
    .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  assign mem_gnt = mem_req & gnt_en;

  // zero-wait responder: data one cycle after grant
  always @(posedge clk) begin
    mem_rvalid <= 1'b0;
    mem_err    <= 1'b0;
    if (mem_req && mem_gnt) begin
      mem_rvalid <= 1'b1;
      mem_rdata  <= mem[mem_addr[9:2]];
      mem_err    <= err_arm;
      beats      <= beats + 1;
      g_addr     <= mem_addr;
      g_we       <= mem_we;
      g_wmask    <= mem_wmask;
      g_wdata    <= mem_wdata;
    end
    if (mem_req) req_hi <= req_hi + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run(input logic st, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    b0 = beats;
    rh0 = req_hi;
    req_valid = 1'b1;
    req_store = st;
    req_funct3 = f3;
    req_addr = a;
    req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    r_lat = 1;
    while (!rsp_valid && r_lat < 100) begin
      @(posedge clk);
      #1 r_lat++;
    end
    chk("rsp_seen", rsp_valid, 1'b1);
    r_data = rsp_data;
    r_err = rsp_err;
  endtask

  task automatic finish_rsp();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[64]  = 32'hDEADBEEF;
    mem[127] = 32'h44332211;
    mem[128] = 32'h88776655;

    #12;
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    chk("rst_rsp_err", rsp_err, 2'b00);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wmask", mem_wmask, 4'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    run(1'b0, 3'b010, 32'h100, 32'h0);
    chk("lw_addr", g_addr, 32'h100);
    chk("lw_wmask", g_wmask, 4'b0000);
    chk("lw_data", r_data, 32'hDEADBEEF);
    chk("lw_err", r_err, 2'b00);
    chk("lw_lat", r_lat, 3);
    finish_rsp();

    mem[64] = 32'h80112233;
    run(1'b0, 3'b000, 32'h103, 32'h0);
    chk("lb_data", r_data, 32'hFFFFFF80);
    finish_rsp();
    run(1'b0, 3'b100, 32'h103, 32'h0);
    chk("lbu_data", r_data, 32'h00000080);
    finish_rsp();

    run(1'b1, 3'b001, 32'h102, 32'h0000ABCD);
    chk("sh_we", g_we, 1'b1);
    chk("sh_wmask", g_wmask, 4'b1100);
    chk("sh_wdata", g_wdata, 32'hABCD0000);
    chk("sh_err", r_err, 2'b00);
    chk("sh_data", r_data, 32'h0);
    finish_rsp();

    mem[64] = 32'hABCD2233;
    run(1'b0, 3'b101, 32'h102, 32'h0);
    chk("lhu_data", r_data, 32'h0000ABCD);
    finish_rsp();
    run(1'b0, 3'b001, 32'h101, 32'h0);
    chk("lh_off1_data", r_data, 32'hFFFFCD22);
    chk("lh_off1_beats", beats - b0, 1);
    finish_rsp();

    run(1'b0, 3'b011, 32'h100, 32'h0);
    chk("ill_ld_err", r_err, 2'b11);
    chk("ill_ld_lat", r_lat, 1);
    chk("ill_ld_beats", beats - b0, 0);
    finish_rsp();
    run(1'b1, 3'b100, 32'h100, 32'h5);
    chk("ill_st_err", r_err, 2'b11);
    chk("ill_st_req", req_hi - rh0, 0);
    finish_rsp();

    run(1'b0, 3'b010, 32'h1FE, 32'h0);
`ifdef LSU_MISALIGNED_EN
    chk("mis_lw_beats", beats - b0, 2);
    chk("mis_lw_addr1", g_addr, 32'h200);
    chk("mis_lw_data", r_data, 32'h66554433);
    chk("mis_lw_err", r_err, 2'b00);
    chk("mis_lw_lat", r_lat, 5);
`else
    chk("mis_lw_beats", beats - b0, 0);
    chk("mis_lw_req", req_hi - rh0, 0);
    chk("mis_lw_data", r_data, 32'h0);
    chk("mis_lw_err", r_err, 2'b01);
    chk("mis_lw_lat", r_lat, 1);
`endif
    finish_rsp();

    gnt_en = 1'b0;
    run(1'b0, 3'b010, 32'h100, 32'h0);
    chk("to_req_cycles", req_hi - rh0, 4);
    chk("to_err", r_err, 2'b10);
    chk("to_data", r_data, 32'h0);
    chk("to_lat", r_lat, 5);
    gnt_en = 1'b1;
    finish_rsp();
    chk("to_req_low", mem_req, 1'b0);
    run(1'b0, 3'b010, 32'h100, 32'h0);
    chk("after_to_data", r_data, 32'hABCD2233);
    chk("after_to_err", r_err, 2'b00);
    finish_rsp();

    err_arm = 1'b1;
    rsp_ready = 1'b0;
`ifdef LSU_MISALIGNED_EN
    run(1'b1, 3'b010, 32'h1FE, 32'h11223344);
    chk("serr_wmask", g_wmask, 4'b1100);
    chk("serr_wdata", g_wdata, 32'h33440000);
`else
    run(1'b1, 3'b010, 32'h1FC, 32'h11223344);
    chk("serr_wmask", g_wmask, 4'b1111);
    chk("serr_wdata", g_wdata, 32'h11223344);
`endif
    err_arm = 1'b0;
    chk("serr_beats", beats - b0, 1);
    chk("serr_err", r_err, 2'b10);
    chk("serr_data", r_data, 32'h0);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", rsp_valid, 1'b1);
      chk("hold_err", rsp_err, 2'b10);
      chk("hold_data", rsp_data, 32'h0);
    end
    chk("serr_no_beat1", beats - b0, 1);
    rsp_ready = 1'b1;
    finish_rsp();
    chk("serr_idle", req_ready, 1'b1);

    gnt_en = 1'b0;
    @(negedge clk);
    req_valid = 1'b1;
    req_store = 1'b0;
    req_funct3 = 3'b010;
    req_addr = 32'h100;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_req", mem_req, 1'b0);
    chk("mid_rst_ready", req_ready, 1'b1);
    chk("mid_rst_valid", rsp_valid, 1'b0);
    gnt_en = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    run(1'b0, 3'b100, 32'h101, 32'h0);
    chk("post_rst_lbu", r_data, 32'h00000022);
    finish_rsp();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
